// File: rtl/merge_run_scheduler.sv
// Feeds a two-lane merger from two source runs, appending a zero terminator per lane, and
// tracks merged output until the pair completes. Optional: MERGE_RUN_SCHEDULER_ZERO_GUARD_EN.

module merge_run_scheduler_lane #(
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_active,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic [DATA_WIDTH-1:0] i_src_data,
    input  logic                  i_src_valid,
    output logic                  o_src_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_empty,
    input  logic                  i_read,
    output logic                  o_term_done,
    output logic                  o_zero_hit
);
    logic [DATA_WIDTH-1:0] data_q, data_d, fwd;
    logic [LEN_WIDTH-1:0]  sent_q, sent_d;
    logic vld_q, vld_d, is_term_q, is_term_d;
    logic term_sent_q, term_sent_d, term_done_q, term_done_d;
    logic pop, free, more, ld_src, ld_term;

    assign pop         = i_read & vld_q;
    assign free        = ~vld_q | i_read;
    assign more        = sent_q < i_len;
    assign o_src_ready = i_active & free & more;
    assign ld_src      = o_src_ready & i_src_valid;
    assign ld_term     = i_active & free & ~more & ~term_sent_q;

`ifdef MERGE_RUN_SCHEDULER_ZERO_GUARD_EN
    // A zero payload would alias the terminator, so mark it by forcing bit 0.
    logic src_zero;
    assign src_zero   = (i_src_data == '0);
    assign fwd        = i_src_data | {{(DATA_WIDTH-1){1'b0}}, src_zero};
    assign o_zero_hit = ld_src & src_zero;
`else
    assign fwd        = i_src_data;
    assign o_zero_hit = 1'b0;
`endif

    always_comb begin
        data_d      = data_q;
        vld_d       = vld_q;
        is_term_d   = is_term_q;
        sent_d      = sent_q;
        term_sent_d = term_sent_q;
        term_done_d = term_done_q;
        if (pop) begin
            vld_d = 1'b0;
            if (is_term_q) term_done_d = 1'b1;
        end
        if (ld_src) begin
            data_d    = fwd;
            vld_d     = 1'b1;
            is_term_d = 1'b0;
            sent_d    = sent_q + 1'b1;
        end else if (ld_term) begin
            data_d      = '0;
            vld_d       = 1'b1;
            is_term_d   = 1'b1;
            term_sent_d = 1'b1;
        end
        if (i_start) begin
            data_d      = '0;
            vld_d       = 1'b0;
            is_term_d   = 1'b0;
            sent_d      = '0;
            term_sent_d = 1'b0;
            term_done_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_q      <= '0;
            vld_q       <= 1'b0;
            is_term_q   <= 1'b0;
            sent_q      <= '0;
            term_sent_q <= 1'b0;
            term_done_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            vld_q       <= vld_d;
            is_term_q   <= is_term_d;
            sent_q      <= sent_d;
            term_sent_q <= term_sent_d;
            term_done_q <= term_done_d;
        end
    end

    assign o_data      = data_q;
    assign o_empty     = ~vld_q;
    assign o_term_done = term_done_q;
endmodule

module merge_run_scheduler #(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 80,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_desc_valid,
    output logic                  o_desc_ready,
    input  logic [LEN_WIDTH-1:0]  i_desc_len_a,
    input  logic [LEN_WIDTH-1:0]  i_desc_len_b,
    input  logic [DATA_WIDTH-1:0] i_src_a_data,
    input  logic                  i_src_a_valid,
    output logic                  o_src_a_ready,
    input  logic [DATA_WIDTH-1:0] i_src_b_data,
    input  logic                  i_src_b_valid,
    output logic                  o_src_b_ready,
    output logic [DATA_WIDTH-1:0] o_fifo_1,
    output logic                  o_fifo_1_empty,
    input  logic                  i_fifo_1_read,
    output logic [DATA_WIDTH-1:0] o_fifo_2,
    output logic                  o_fifo_2_empty,
    input  logic                  i_fifo_2_read,
    input  logic                  i_out_write,
    input  logic [DATA_WIDTH-1:0] i_out_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err_zero
);
    // The key field rides inside the tuple untouched; it only has to fit.
    if (KEY_WIDTH > DATA_WIDTH) begin : g_key_chk
        $error("KEY_WIDTH must not exceed DATA_WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_a_q, len_a_d, len_b_q, len_b_d;
    logic [LEN_WIDTH:0]   out_cnt_q, out_cnt_d, total;
    logic                 err_q, err_d;
    logic                 start, active, tdone_a, tdone_b, zhit_a, zhit_b;

    assign start  = (state_q == S_IDLE) & i_desc_valid;
    assign active = (state_q == S_STREAM);
    assign total  = {1'b0, len_a_q} + {1'b0, len_b_q};

    merge_run_scheduler_lane #(.DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_lane_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start), .i_active(active), .i_len(len_a_q),
        .i_src_data(i_src_a_data), .i_src_valid(i_src_a_valid), .o_src_ready(o_src_a_ready),
        .o_data(o_fifo_1), .o_empty(o_fifo_1_empty), .i_read(i_fifo_1_read),
        .o_term_done(tdone_a), .o_zero_hit(zhit_a)
    );

    merge_run_scheduler_lane #(.DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_lane_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start), .i_active(active), .i_len(len_b_q),
        .i_src_data(i_src_b_data), .i_src_valid(i_src_b_valid), .o_src_ready(o_src_b_ready),
        .o_data(o_fifo_2), .o_empty(o_fifo_2_empty), .i_read(i_fifo_2_read),
        .o_term_done(tdone_b), .o_zero_hit(zhit_b)
    );

    always_comb begin
        state_d   = state_q;
        len_a_d   = len_a_q;
        len_b_d   = len_b_q;
        out_cnt_d = out_cnt_q;
        o_done    = 1'b0;
        err_d     = err_q | zhit_a | zhit_b;
        // Zero tuples are terminators passing through the merger, not payload.
        if ((state_q == S_STREAM || state_q == S_DRAIN) && i_out_write && (i_out_data != '0))
            out_cnt_d = out_cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (i_desc_valid) begin
                    state_d   = S_STREAM;
                    len_a_d   = i_desc_len_a;
                    len_b_d   = i_desc_len_b;
                    out_cnt_d = '0;
                end
            end
            S_STREAM: if (tdone_a && tdone_b) state_d = S_DRAIN;
            S_DRAIN:  if (out_cnt_q == total) state_d = S_DONE;
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            len_a_q   <= '0;
            len_b_q   <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_a_q   <= len_a_d;
            len_b_q   <= len_b_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end

    assign o_desc_ready = (state_q == S_IDLE);
    assign o_busy       = (state_q != S_IDLE);
    assign o_err_zero   = err_q;
endmodule
